// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - programmable serial pattern detector with run control and hit counting
module seq_detect_ctrl #(
  parameter int                PAT_W       = 6,
  parameter int                CNT_W       = 8,
  parameter logic [PAT_W-1:0]  RST_PATTERN = 6'b101011
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic [CNT_W-1:0] cfg_threshold,
  input  logic             cfg_overlap,
  input  logic             start,
  input  logic             stop,
  input  logic             data_valid,
  input  logic             data_in,
  output logic             match_pulse,
  output logic [CNT_W-1:0] hit_count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  localparam int                FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  // Encoding 3 is never entered; the next-state logic treats it like IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2,
    ST_RSVD  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pattern_q, pattern_d;
  logic [PAT_W-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]   thresh_q, thresh_d;
  logic               overlap_q, overlap_d;
  logic [PAT_W-1:0]   shift_q, shift_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]   hit_q, hit_d;
  logic               match_q, match_d;

  logic [PAT_W-1:0]   shift_nxt;
  logic [FILL_W-1:0]  fill_nxt;
  logic [CNT_W-1:0]   hit_inc;
  logic               hit;

  // Candidate window after accepting data_in, and whether it counts as a match.
  assign shift_nxt = {shift_q[PAT_W-2:0], data_in};
  assign fill_nxt  = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
  assign hit       = (fill_nxt == FILL_FULL) && (((shift_nxt ^ pattern_q) & mask_q) == '0);
  assign hit_inc   = (&hit_q) ? hit_q : hit_q + CNT_W'(1);

  // State, configuration and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pattern_q <= RST_PATTERN;
      mask_q    <= '1;
      thresh_q  <= CNT_W'(1);
      overlap_q <= 1'b1;
      shift_q   <= '0;
      fill_q    <= '0;
      hit_q     <= '0;
      match_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      mask_q    <= mask_d;
      thresh_q  <= thresh_d;
      overlap_q <= overlap_d;
      shift_q   <= shift_d;
      fill_q    <= fill_d;
      hit_q     <= hit_d;
      match_q   <= match_d;
    end
  end

  // Run sequencing: config capture in IDLE, shifting and hit counting in ARMED.
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    mask_d    = mask_q;
    thresh_d  = thresh_q;
    overlap_d = overlap_q;
    shift_d   = shift_q;
    fill_d    = fill_q;
    hit_d     = hit_q;
    match_d   = 1'b0;

    case (state_q)
      ST_ARMED: begin
        if (stop) begin
          // A hit sampled on the stop edge is dropped.
          state_d = ST_IDLE;
        end else if (data_valid) begin
          shift_d = shift_nxt;
          fill_d  = fill_nxt;
          if (hit) begin
            match_d = 1'b1;
            hit_d   = hit_inc;
            if (!overlap_q) begin
              fill_d = '0;
            end
            if ((thresh_q != '0) && (hit_inc == thresh_q)) begin
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          shift_d = '0;
          fill_d  = '0;
          hit_d   = '0;
          state_d = ST_ARMED;
        end
      end
      default: begin
        if (cfg_valid) begin
          pattern_d = cfg_pattern;
          mask_d    = cfg_mask;
          thresh_d  = cfg_threshold;
          overlap_d = cfg_overlap;
        end
        if (start) begin
          shift_d = '0;
          fill_d  = '0;
          hit_d   = '0;
          state_d = ST_ARMED;
        end
      end
    endcase
  end

  assign busy        = (state_q == ST_ARMED);
  assign done        = (state_q == ST_DONE);
  assign cfg_ready   = !(busy || done);
  assign state       = state_q;
  assign match_pulse = match_q;
  assign hit_count   = hit_q;

endmodule
